player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Parametrised per-frame player movement controller for the USB+HDMI game.
- Decodes N keyboard slots and runs an explicit jump FSM (ground/rise/hover/fall) with multi-jump, capped gravity and collision snapping.
- Outputs the clamped sprite centre, which feeds the sprite renderer and collision unit.
- Replaces the ad-hoc counter/flag jump logic with registered velocity and no combinational feedback.

Parameters:
KEY_SLOTS, 4, number of 8-bit keycode slots scanned
POS_W, 10, position width in pixels
X_START / Y_START, 20 / 300, respawn centre
X_MIN / X_MAX, 0 / 639, horizontal screen limits
Y_MIN, 7, top screen limit
HALF_SIZE, 15, sprite half-width, driven on size
WALK_STEP / BOOST_STEP, 1 / 2, horizontal px/frame, normal / get_charged
JUMP_VEL, 8, upward px/frame during RISE
RISE_FRAMES / HOVER_FRAMES, 7 / 5, maximum RISE length and fixed HOVER length
GRAVITY / MAX_FALL, 1 / 3, fall acceleration and terminal speed (px/frame)
MAX_JUMPS, 2, jumps allowed before landing (2 = double jump)
KEY_LEFT / KEY_RIGHT / KEY_JUMP, 8'h04 / 8'h07 / 8'h1A, HID codes (A / D / W)

Ports:
frame_clk  in  1  clock, one tick per video frame
Reset  in  1  synchronous, active-high
keycode  in  8*KEY_SLOTS  packed key slots, slot 0 = bits [7:0]
respawn  in  1  synchronous return to start (game-over/menu state)
in_air  in  1  no floor under the sprite
get_charged  in  1  speed boost active
touch_down, touch_up, touch_left, touch_right  in  1 each  collision flags
touch_down_y, touch_up_y, touch_left_x, touch_right_x  in  POS_W each  snap coordinates
pos_x, pos_y  out  POS_W  sprite centre
size  out  POS_W  constant HALF_SIZE
vel_y  out  5 signed  current vertical velocity, + = down
state  out  2  motion_state_t
jumps_used  out  2  jumps since last landing
go_up, go_left, go_right  out  1 each  animation hints

Behaviour:
- Reset, or respawn while not in Reset: pos=(X_START,Y_START), state=GROUND, vel_y=0, jumps_used=0, go_*=0, jump_prev=0. Reset has priority.
- All outputs are registered and update once per frame_clk edge (1-frame latency from inputs).
- Key decode: a key is held if any slot equals its code. RIGHT has priority over LEFT.
- jump_edge = held(JUMP) & ~jump_prev, with jump_prev registered. Holding the jump key never re-triggers.
- Horizontal: dx = ±(get_charged ? BOOST_STEP : WALK_STEP).
  - touch_right: next x = touch_right_x.
  - else touch_left: next x = touch_left_x.
- Vertical by state:
  - RISE: dy = -JUMP_VEL.
  - HOVER: dy = 0.
  - FALL: vel_y <= min(vel_y+GRAVITY, MAX_FALL); dy = the updated vel_y.
  - GROUND: dy = 0.
- FSM transitions:
  - GROUND: jump_edge -> RISE, cnt=0, jumps_used=1. Else in_air -> FALL, vel_y=0.
  - RISE: touch_up -> FALL, vel_y=0, y snapped to touch_up_y. Else jump released, or cnt==RISE_FRAMES-1 -> HOVER, cnt=0.
  - HOVER: cnt==HOVER_FRAMES-1 -> FALL, vel_y=0.
  - FALL: jump_edge && jumps_used<MAX_JUMPS -> RISE, jumps_used+1, cnt=0.
  - Any state: touch_down && vel_y>=0 (or state GROUND) -> GROUND, y=touch_down_y, vel_y=0, jumps_used=0. Landing beats a same-frame jump_edge.
- Arithmetic: next position is computed signed, POS_W+2 bits, then clamped:
  - x to [X_MIN+HALF_SIZE, X_MAX-HALF_SIZE]. No bounce.
  - y >= Y_MIN+HALF_SIZE. Hitting that clamp in RISE forces FALL.
  - No wrap-around is ever permitted.
- go_up=(state==RISE). go_left/go_right = held direction after priority.

Optional Feature:
COYOTE_EN
- Defined: a GROUND->FALL transition with jumps_used==0 opens a window of COYOTE_FRAMES=4 frames. A jump_edge inside the window is a ground jump (jumps_used=1).
- Undefined: the FSM behaves as specified above, and the window counter is not built.

Decomposition:
- player_motion_pkg holds motion_state_t {GROUND,RISE,HOVER,FALL} and the default HID key-code constants.
- Sub-module key_match (parameter KEY_SLOTS): keycode bus + code -> held. Instantiated three times.

Test Plan:
- Reset then idle with in_air=0 -> pos=(20,300), state GROUND, vel_y=0 on every frame.
- Hold 8'h07 in slot 2 for 10 frames, with get_charged=1 from frame 5 -> x = 20+4·1+6·2 = 36; go_right=1.
- Press jump and hold, in_air=1 -> y drops by 8 for 7 frames (to 244), HOVER 5 frames, then falls +1, +2, +3, +3…; a held key does not re-jump.
- Mid-FALL jump_edge -> second RISE with jumps_used=2; a third press is ignored; touch_down with touch_down_y=300 -> GROUND, jumps_used=0.
- Hold LEFT from x=20 -> x clamps at 15 with no bounce. Hold RIGHT toward 639 -> x clamps at 624.
- respawn pulse mid-RISE -> next frame pos=(20,300), state GROUND. With COYOTE_EN, a jump 3 frames after walking off a ledge -> RISE with jumps_used=1.

Source files
------------

// File: rtl/player_motion_pkg.sv
// Shared types and default HID key codes for the player movement controller.
package player_motion_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    HOVER  = 2'd2,
    FALL   = 2'd3
  } motion_state_t;

  localparam logic [7:0] KEY_LEFT_DEFAULT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEFAULT = 8'h07;
  localparam logic [7:0] KEY_JUMP_DEFAULT  = 8'h1A;

  localparam int unsigned COYOTE_FRAMES = 4;

endpackage

// File: rtl/player_motion_key_match.sv
// Reports whether a given key code is present in any slot of the packed keyboard bus.
module key_match #(
  parameter int unsigned KEY_SLOTS = 4
) (
  input  logic [8*KEY_SLOTS-1:0] keycode_i,
  input  logic [7:0]             code_i,
  output logic                   held_c
);

  always_comb begin
    held_c = 1'b0;
    for (int i = 0; i < int'(KEY_SLOTS); i++) begin
      if (keycode_i[8*i +: 8] == code_i) held_c = 1'b1;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player movement: key decode, jump FSM with multi-jump, gravity and collision snapping.
// Optional macro COYOTE_EN adds a short post-ledge window in which a jump counts as a ground jump.
module player_motion
  import player_motion_pkg::*;
#(
  parameter int unsigned KEY_SLOTS    = 4,
  parameter int unsigned POS_W        = 10,
  parameter int unsigned X_START      = 20,
  parameter int unsigned Y_START      = 300,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MIN        = 7,
  parameter int unsigned HALF_SIZE    = 15,
  parameter int unsigned WALK_STEP    = 1,
  parameter int unsigned BOOST_STEP   = 2,
  parameter int unsigned JUMP_VEL     = 8,
  parameter int unsigned RISE_FRAMES  = 7,
  parameter int unsigned HOVER_FRAMES = 5,
  parameter int unsigned GRAVITY      = 1,
  parameter int unsigned MAX_FALL     = 3,
  parameter int unsigned MAX_JUMPS    = 2,
  parameter logic [7:0]  KEY_LEFT     = KEY_LEFT_DEFAULT,
  parameter logic [7:0]  KEY_RIGHT    = KEY_RIGHT_DEFAULT,
  parameter logic [7:0]  KEY_JUMP     = KEY_JUMP_DEFAULT
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic                   respawn,
  input  logic                   in_air,
  input  logic                   get_charged,
  input  logic                   touch_down,
  input  logic                   touch_up,
  input  logic                   touch_left,
  input  logic                   touch_right,
  input  logic [POS_W-1:0]       touch_down_y,
  input  logic [POS_W-1:0]       touch_up_y,
  input  logic [POS_W-1:0]       touch_left_x,
  input  logic [POS_W-1:0]       touch_right_x,
  output logic [POS_W-1:0]       pos_x,
  output logic [POS_W-1:0]       pos_y,
  output logic [POS_W-1:0]       size,
  output logic signed [4:0]      vel_y,
  output logic [1:0]             state,
  output logic [1:0]             jumps_used,
  output logic                   go_up,
  output logic                   go_left,
  output logic                   go_right
);

  localparam int unsigned PW2   = POS_W + 2;
  localparam int unsigned CNT_MAX = (RISE_FRAMES > HOVER_FRAMES) ? RISE_FRAMES : HOVER_FRAMES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic signed [PW2-1:0] X_LO = PW2'(X_MIN + HALF_SIZE);
  localparam logic signed [PW2-1:0] X_HI = PW2'(X_MAX - HALF_SIZE);
  localparam logic signed [PW2-1:0] Y_LO = PW2'(Y_MIN + HALF_SIZE);
  localparam logic signed [PW2-1:0] P_HI = PW2'((1 << POS_W) - 1);
  localparam logic signed [4:0]     VEL_RISE = -5'(JUMP_VEL);
  localparam logic signed [5:0]     GRAV_S   = 6'(GRAVITY);
  localparam logic signed [5:0]     MAXF_S   = 6'(MAX_FALL);

  logic held_left, held_right, held_jump, jump_edge;

  key_match #(.KEY_SLOTS(KEY_SLOTS)) u_key_left  (.keycode_i(keycode), .code_i(KEY_LEFT),  .held_c(held_left));
  key_match #(.KEY_SLOTS(KEY_SLOTS)) u_key_right (.keycode_i(keycode), .code_i(KEY_RIGHT), .held_c(held_right));
  key_match #(.KEY_SLOTS(KEY_SLOTS)) u_key_jump  (.keycode_i(keycode), .code_i(KEY_JUMP),  .held_c(held_jump));

  motion_state_t        state_q, state_d;
  logic [POS_W-1:0]     x_q, x_d, y_q, y_d;
  logic signed [4:0]    vel_q, vel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           jumps_q, jumps_d;
  logic                 jump_prev_q;
  logic                 go_up_q, go_left_q, go_right_q;
`ifdef COYOTE_EN
  localparam int unsigned COY_W = $clog2(COYOTE_FRAMES + 1);
  logic [COY_W-1:0]     coy_q, coy_d;
`endif

  logic signed [PW2-1:0] step, dx, x_sum, x_clamp;
  logic signed [PW2-1:0] dy, y_sum, y_clamp;
  logic signed [5:0]     vel_inc;
  logic signed [4:0]     vel_fall;
  logic                  y_hit;

  assign jump_edge = held_jump & ~jump_prev_q;

  // Horizontal: walk/boost step, collision snap, then clamp to the playfield.
  always_comb begin
    step = get_charged ? PW2'(BOOST_STEP) : PW2'(WALK_STEP);
    dx   = '0;
    if (held_right)     dx = step;
    else if (held_left) dx = -step;
    x_sum = $signed({2'b00, x_q}) + dx;
    if (touch_right)     x_sum = $signed({2'b00, touch_right_x});
    else if (touch_left) x_sum = $signed({2'b00, touch_left_x});
    x_clamp = x_sum;
    if (x_sum < X_LO)      x_clamp = X_LO;
    else if (x_sum > X_HI) x_clamp = X_HI;
  end

  // Vertical displacement for this frame, derived from the current state.
  always_comb begin
    vel_inc  = $signed({vel_q[4], vel_q}) + GRAV_S;
    vel_fall = (vel_inc > MAXF_S) ? MAXF_S[4:0] : vel_inc[4:0];
    dy = '0;
    case (state_q)
      RISE:    dy = {{(PW2-5){VEL_RISE[4]}}, VEL_RISE};
      FALL:    dy = {{(PW2-5){vel_fall[4]}}, vel_fall};
      default: dy = '0;
    endcase
    y_sum   = $signed({2'b00, y_q}) + dy;
    y_hit   = (y_sum < Y_LO);
    y_clamp = y_sum;
    if (y_hit)             y_clamp = Y_LO;
    else if (y_sum > P_HI) y_clamp = P_HI;
  end

  // Jump FSM next state; landing overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jumps_d = jumps_q;
    vel_d   = vel_q;
    x_d     = x_clamp[POS_W-1:0];
    y_d     = y_clamp[POS_W-1:0];
`ifdef COYOTE_EN
    coy_d   = '0;
`endif
    case (state_q)
      GROUND: begin
        vel_d = '0;
        if (jump_edge) begin
          state_d = RISE;
          cnt_d   = '0;
          jumps_d = 2'd1;
          vel_d   = VEL_RISE;
        end else if (in_air) begin
          state_d = FALL;
`ifdef COYOTE_EN
          if (jumps_q == 2'd0) coy_d = COY_W'(COYOTE_FRAMES);
`endif
        end
      end
      RISE: begin
        vel_d = VEL_RISE;
        cnt_d = cnt_q + CNT_W'(1);
        if (touch_up) begin
          state_d = FALL;
          vel_d   = '0;
          y_d     = touch_up_y;
        end else if (y_hit) begin
          state_d = FALL;
          vel_d   = '0;
        end else if (!held_jump || cnt_q == CNT_W'(RISE_FRAMES - 1)) begin
          state_d = HOVER;
          cnt_d   = '0;
          vel_d   = '0;
        end
      end
      HOVER: begin
        vel_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HOVER_FRAMES - 1)) begin
          state_d = FALL;
          cnt_d   = '0;
        end
      end
      FALL: begin
        vel_d = vel_fall;
`ifdef COYOTE_EN
        if (coy_q != '0) coy_d = coy_q - COY_W'(1);
        if (jump_edge && coy_q != '0) begin
          state_d = RISE;
          cnt_d   = '0;
          jumps_d = 2'd1;
          vel_d   = VEL_RISE;
          coy_d   = '0;
        end else if (jump_edge && jumps_q < 2'(MAX_JUMPS)) begin
`else
        if (jump_edge && jumps_q < 2'(MAX_JUMPS)) begin
`endif
          state_d = RISE;
          cnt_d   = '0;
          jumps_d = jumps_q + 2'd1;
          vel_d   = VEL_RISE;
        end
      end
      default: state_d = GROUND;
    endcase
    if (touch_down && (!vel_q[4] || state_q == GROUND)) begin
      state_d = GROUND;
      y_d     = touch_down_y;
      vel_d   = '0;
      jumps_d = 2'd0;
      cnt_d   = '0;
`ifdef COYOTE_EN
      coy_d   = '0;
`endif
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || respawn) begin
      state_q     <= GROUND;
      x_q         <= POS_W'(X_START);
      y_q         <= POS_W'(Y_START);
      vel_q       <= '0;
      cnt_q       <= '0;
      jumps_q     <= '0;
      jump_prev_q <= 1'b0;
      go_up_q     <= 1'b0;
      go_left_q   <= 1'b0;
      go_right_q  <= 1'b0;
`ifdef COYOTE_EN
      coy_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      cnt_q       <= cnt_d;
      jumps_q     <= jumps_d;
      jump_prev_q <= held_jump;
      go_up_q     <= (state_d == RISE);
      go_left_q   <= held_left & ~held_right;
      go_right_q  <= held_right;
`ifdef COYOTE_EN
      coy_q       <= coy_d;
`endif
    end
  end

  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign size       = POS_W'(HALF_SIZE);
  assign vel_y      = vel_q;
  assign state      = state_q;
  assign jumps_used = jumps_q;
  assign go_up      = go_up_q;
  assign go_left    = go_left_q;
  assign go_right   = go_right_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed self-checking bench for player_motion with hand-computed expectations.
module tb_player_motion;
  import player_motion_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset, respawn, in_air, get_charged;
  logic [31:0] keycode;
  logic        touch_down, touch_up, touch_left, touch_right;
  logic [9:0]  touch_down_y, touch_up_y, touch_left_x, touch_right_x;
  logic [9:0]  pos_x, pos_y, size;
  logic signed [4:0] vel_y;
  logic [1:0]  state, jumps_used;
  logic        go_up, go_left, go_right;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 frame_clk = ~frame_clk;

  player_motion dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .respawn(respawn),
    .in_air(in_air), .get_charged(get_charged),
    .touch_down(touch_down), .touch_up(touch_up), .touch_left(touch_left), .touch_right(touch_right),
    .touch_down_y(touch_down_y), .touch_up_y(touch_up_y),
    .touch_left_x(touch_left_x), .touch_right_x(touch_right_x),
    .pos_x(pos_x), .pos_y(pos_y), .size(size), .vel_y(vel_y), .state(state),
    .jumps_used(jumps_used), .go_up(go_up), .go_left(go_left), .go_right(go_right)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_motion(input string tag, input int x, input int y, input int st, input int vel, input int jmp);
    chk({tag, ".x"},     {22'd0, pos_x}, x);
    chk({tag, ".y"},     {22'd0, pos_y}, y);
    chk({tag, ".state"}, {30'd0, state}, st);
    chk({tag, ".vel"},   32'(vel_y), vel);
    chk({tag, ".jumps"}, {30'd0, jumps_used}, jmp);
  endtask

  initial begin
    Reset = 1'b1; respawn = 1'b0; in_air = 1'b0; get_charged = 1'b0; keycode = '0;
    touch_down = 1'b0; touch_up = 1'b0; touch_left = 1'b0; touch_right = 1'b0;
    touch_down_y = '0; touch_up_y = '0; touch_left_x = '0; touch_right_x = '0;
    step(2);
    Reset = 1'b0;
    chk_motion("reset", 20, 300, int'(GROUND), 0, 0);
    chk("reset.size", {22'd0, size}, 15);
    chk("reset.go", {29'd0, go_up, go_left, go_right}, 0);

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_motion("idle", 20, 300, int'(GROUND), 0, 0);
    end

    // Walk right, key in slot 2, boost from frame 5
    keycode = {8'h00, 8'h07, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      get_charged = (i >= 4);
      step(1);
      if (i == 3) chk("walk4.x", {22'd0, pos_x}, 24);
    end
    chk("walk.x", {22'd0, pos_x}, 36);
    chk("walk.go_right", {31'd0, go_right}, 1);
    keycode = '0; get_charged = 1'b0;
    step(1);
    chk("stop.x", {22'd0, pos_x}, 36);
    chk("stop.go_right", {31'd0, go_right}, 0);

    // Held jump: 7 rise frames, 5 hover frames, then gravity
    keycode = {24'h0, 8'h1A}; in_air = 1'b1;
    step(1);
    chk_motion("jump0", 36, 300, int'(RISE), -8, 1);
    chk("jump0.go_up", {31'd0, go_up}, 1);
    step(6);
    chk_motion("rise6", 36, 252, int'(RISE), -8, 1);
    step(1);
    chk_motion("rise7", 36, 244, int'(HOVER), 0, 1);
    step(4);
    chk_motion("hover4", 36, 244, int'(HOVER), 0, 1);
    step(1);
    chk_motion("hover5", 36, 244, int'(FALL), 0, 1);
    step(1); chk_motion("fall1", 36, 245, int'(FALL), 1, 1);
    step(1); chk_motion("fall2", 36, 247, int'(FALL), 2, 1);
    step(1); chk_motion("fall3", 36, 250, int'(FALL), 3, 1);
    step(1); chk_motion("fall4", 36, 253, int'(FALL), 3, 1);

    // Second jump mid-fall, then a third press is ignored
    keycode = '0;
    step(1); chk_motion("fall5", 36, 256, int'(FALL), 3, 1);
    keycode = {24'h0, 8'h1A};
    step(1); chk_motion("jump2", 36, 259, int'(RISE), -8, 2);
    keycode = '0;
    step(1); chk_motion("release", 36, 251, int'(HOVER), 0, 2);
    step(5); chk_motion("hover2", 36, 251, int'(FALL), 0, 2);
    keycode = {24'h0, 8'h1A};
    step(1); chk_motion("jump3", 36, 252, int'(FALL), 1, 2);
    keycode = '0; touch_down = 1'b1; touch_down_y = 10'd300; in_air = 1'b0;
    step(1); chk_motion("land", 36, 300, int'(GROUND), 0, 0);
    touch_down = 1'b0;

    // Left clamp after respawn
    respawn = 1'b1;
    step(1);
    respawn = 1'b0;
    chk_motion("respawn", 20, 300, int'(GROUND), 0, 0);
    keycode = {16'h0, 8'h04, 8'h00};
    step(5); chk("left5.x", {22'd0, pos_x}, 15);
    step(3); chk("left8.x", {22'd0, pos_x}, 15);
    chk("left.go_left", {31'd0, go_left}, 1);
    keycode = {16'h0, 8'h07, 8'h04};
    step(1);
    chk("prio.x", {22'd0, pos_x}, 16);
    chk("prio.go", {30'd0, go_left, go_right}, 1);

    // Right snap and clamp
    keycode = {16'h0, 8'h07, 8'h00};
    touch_right = 1'b1; touch_right_x = 10'd630;
    step(1); chk("snapR.x", {22'd0, pos_x}, 624);
    touch_right = 1'b0; get_charged = 1'b1;
    step(3); chk("right.clamp", {22'd0, pos_x}, 624);
    keycode = '0; get_charged = 1'b0;
    touch_left = 1'b1; touch_left_x = 10'd100;
    step(1); chk("snapL.x", {22'd0, pos_x}, 100);
    touch_right = 1'b1; touch_right_x = 10'd200; touch_left_x = 10'd300;
    step(1); chk("snapRL.x", {22'd0, pos_x}, 200);
    touch_right = 1'b0; touch_left = 1'b0;

    // Respawn mid-rise
    in_air = 1'b1; keycode = {24'h0, 8'h1A};
    step(1); chk_motion("rj0", 200, 300, int'(RISE), -8, 1);
    step(1); chk_motion("rj1", 200, 292, int'(RISE), -8, 1);
    respawn = 1'b1;
    step(1); chk_motion("rj.respawn", 20, 300, int'(GROUND), 0, 0);
    respawn = 1'b0;
    step(1); chk_motion("rj.again", 20, 300, int'(RISE), -8, 1);

    // Ceiling snap, then the top clamp forces a fall
    touch_up = 1'b1; touch_up_y = 10'd30;
    step(1); chk_motion("ceil", 20, 30, int'(FALL), 0, 1);
    touch_up = 1'b0; keycode = '0;
    step(1); chk_motion("ceil.fall", 20, 31, int'(FALL), 1, 1);
    keycode = {24'h0, 8'h1A};
    step(1); chk_motion("top.jump", 20, 33, int'(RISE), -8, 2);
    step(1); chk_motion("top.rise", 20, 25, int'(RISE), -8, 2);
    step(1); chk_motion("top.clamp", 20, 22, int'(FALL), 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
